// File: rtl/demux_1x5_reg.sv
// -----------------------------------------------------------------------------
// demux_1x5_reg
//   Registered 1-to-5 demultiplexer. A single data bit is routed to one of
//   five held output channels, chosen by a 3-bit select. Select codes 5..7
//   are rejected and flagged. All outputs are registered (1-cycle latency).
//
//   Optional auto-scan mode (macro DEMUX_SCAN_EN): while scan=1 a pointer
//   steps round-robin through channels 0..4, dwelling DWELL cycles on each,
//   and loads write the channel under the pointer instead of sel.
//   Without the macro the scan input is ignored and the block is manual only.
//
// Parameters
//   HOLD    1: unselected channels keep their value; 0: a write clears others
//   DWELL   cycles per channel in scan mode (>=1)
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   in       in   data bit to route
//   sel      in   channel select (0..4 valid)
//   load     in   write strobe
//   scan     in   auto-scan enable (used only with DEMUX_SCAN_EN)
//   out      out  per-channel held data
//   strobe   out  one-cycle one-hot pulse on the channel just written
//   err      out  one-cycle pulse on a manual load with invalid sel
//   cur_sel  out  effective channel index (0..4)
// -----------------------------------------------------------------------------
module demux_1x5_reg #(
   parameter int unsigned HOLD  = 1,
   parameter int unsigned DWELL = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in,
   input  logic [2:0] sel,
   input  logic       load,
   input  logic       scan,
   output logic [4:0] out,
   output logic [4:0] strobe,
   output logic       err,
   output logic [2:0] cur_sel
);

   logic [4:0] out_q, out_d;
   logic [4:0] strobe_q, strobe_d;
   logic       err_q, err_d;
   logic [2:0] cur_sel_q, cur_sel_d;

   // Scan-side view consumed by the main datapath; constant when not built.
   logic       scan_on;
   logic [2:0] scan_ch;      // channel written by a load in scan mode (pre-edge ptr)
   logic [2:0] scan_ch_nxt;  // pointer value after this edge

`ifdef DEMUX_SCAN_EN
   localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

   logic [2:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign scan_on     = scan;
   assign scan_ch     = ptr_q;
   assign scan_ch_nxt = ptr_d;

   // Pointer and dwell counter are parked at 0 whenever scan is low, so a
   // scan 0->1 transition always starts from channel 0.
   always_comb begin
      ptr_d = '0;
      cnt_d = '0;
      if (scan) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            ptr_d = (ptr_q == 3'd4) ? 3'd0 : ptr_q + 3'd1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            ptr_d = ptr_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end
`else
   localparam int unsigned UNUSED_DWELL = DWELL;
   logic unused_scan;

   assign unused_scan = scan;
   assign scan_on     = 1'b0;
   assign scan_ch     = 3'd0;
   assign scan_ch_nxt = 3'd0;
`endif

   logic       wr;
   logic [2:0] tgt;
   logic [4:0] onehot;

   always_comb begin
      wr        = 1'b0;
      tgt       = 3'd0;
      err_d     = 1'b0;
      cur_sel_d = cur_sel_q;

      if (scan_on) begin
         // sel is ignored and err never fires while scanning.
         wr        = load;
         tgt       = scan_ch;
         cur_sel_d = scan_ch_nxt;
      end else if (load) begin
         if (sel <= 3'd4) begin
            wr        = 1'b1;
            tgt       = sel;
            cur_sel_d = sel;
         end else begin
            err_d = 1'b1;
         end
      end

      onehot   = 5'b00001 << tgt;
      strobe_d = wr ? onehot : '0;

      out_d = out_q;
      if (wr) begin
         if (HOLD != 0) begin
            out_d = (out_q & ~onehot) | (in ? onehot : '0);
         end else begin
            out_d = in ? onehot : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q     <= '0;
         strobe_q  <= '0;
         err_q     <= 1'b0;
         cur_sel_q <= '0;
      end else begin
         out_q     <= out_d;
         strobe_q  <= strobe_d;
         err_q     <= err_d;
         cur_sel_q <= cur_sel_d;
      end
   end

   assign out     = out_q;
   assign strobe  = strobe_q;
   assign err     = err_q;
   assign cur_sel = cur_sel_q;

endmodule

// File: tb/tb_demux_1x5_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_1x5_reg
//   Self-checking bench for demux_1x5_reg. Two instances share one stimulus:
//   A (HOLD=1, DWELL=4) and B (HOLD=0, DWELL=1). Each is compared against a
//   behavioural channel model after every edge, plus directed scenarios.
//   Scan scenarios are compiled in when DEMUX_SCAN_EN is defined.
// -----------------------------------------------------------------------------
module tb_demux_1x5_reg;

`ifdef DEMUX_SCAN_EN
   localparam bit SCAN_BUILT = 1'b1;
`else
   localparam bit SCAN_BUILT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in;
   logic [2:0] sel;
   logic       load;
   logic       scan;

   logic [4:0] out_a, strobe_a, out_b, strobe_b;
   logic       err_a, err_b;
   logic [2:0] cur_a, cur_b;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   always #5 clk = ~clk;

   demux_1x5_reg #(.HOLD(1), .DWELL(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .in(in), .sel(sel), .load(load), .scan(scan),
      .out(out_a), .strobe(strobe_a), .err(err_a), .cur_sel(cur_a)
   );

   demux_1x5_reg #(.HOLD(0), .DWELL(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .in(in), .sel(sel), .load(load), .scan(scan),
      .out(out_b), .strobe(strobe_b), .err(err_b), .cur_sel(cur_b)
   );

   // Behavioural model: per instance, channel contents as an integer bit set,
   // scan position as (channel, cycles spent on it).
   int m_out[2], m_strobe[2], m_err[2], m_cur[2], m_pos[2], m_spent[2];
   int hold_of[2]  = '{1, 0};
   int dwell_of[2] = '{4, 1};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_out[i] = 0; m_strobe[i] = 0; m_err[i] = 0;
         m_cur[i] = 0; m_pos[i] = 0; m_spent[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         int  ch;
         bit  wr;
         int  d;
         wr = 1'b0;
         ch = 0;
         d  = (in === 1'b1) ? 1 : 0;
         m_strobe[i] = 0;
         m_err[i]    = 0;
         if (SCAN_BUILT && scan === 1'b1) begin
            if (load === 1'b1) begin
               wr = 1'b1;
               ch = m_pos[i];
            end
            m_spent[i] = m_spent[i] + 1;
            if (m_spent[i] == dwell_of[i]) begin
               m_spent[i] = 0;
               m_pos[i]   = (m_pos[i] + 1) % 5;
            end
            m_cur[i] = m_pos[i];
         end else begin
            m_pos[i]   = 0;
            m_spent[i] = 0;
            if (load === 1'b1) begin
               if (int'(sel) < 5) begin
                  wr       = 1'b1;
                  ch       = int'(sel);
                  m_cur[i] = ch;
               end else begin
                  m_err[i] = 1;
               end
            end
         end
         if (wr) begin
            if (hold_of[i] == 0) m_out[i] = 0;
            m_out[i]    = (m_out[i] & ~(1 << ch)) | (d << ch);
            m_strobe[i] = 1 << ch;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, "_out_a"},    32'(out_a),    32'(m_out[0]));
      check_eq({tag, "_strobe_a"}, 32'(strobe_a), 32'(m_strobe[0]));
      check_eq({tag, "_err_a"},    32'(err_a),    32'(m_err[0]));
      check_eq({tag, "_cur_a"},    32'(cur_a),    32'(m_cur[0]));
      check_eq({tag, "_out_b"},    32'(out_b),    32'(m_out[1]));
      check_eq({tag, "_strobe_b"}, 32'(strobe_b), 32'(m_strobe[1]));
      check_eq({tag, "_err_b"},    32'(err_b),    32'(m_err[1]));
      check_eq({tag, "_cur_b"},    32'(cur_b),    32'(m_cur[1]));
   endtask

   // Drive inputs between edges, clock once, compare 1 time unit after the edge.
   task automatic step(input bit l, input logic [2:0] s, input bit d, input bit sc, input string tag);
      load = l; sel = s; in = d; scan = sc;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      model_reset();
      check_all("rst");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b1;
      load = 1'b0; sel = '0; in = 1'b0; scan = 1'b0;
      model_reset();
      #3;
      do_reset();

      // Basic write, then hold.
      step(1'b1, 3'd2, 1'b1, 1'b0, "t1a");
      check_eq("t1_out",    32'(out_a),    32'h04);
      check_eq("t1_strobe", 32'(strobe_a), 32'h04);
      check_eq("t1_err",    32'(err_a),    32'h0);
      check_eq("t1_cur",    32'(cur_a),    32'h2);
      step(1'b0, 3'd0, 1'b0, 1'b0, "t1b");
      check_eq("t1_strobe_clr", 32'(strobe_a), 32'h0);
      check_eq("t1_out_hold",   32'(out_a),    32'h04);

      // Invalid select.
      step(1'b1, 3'd5, 1'b1, 1'b0, "t2a");
      check_eq("t2_err",  32'(err_a), 32'h1);
      check_eq("t2_out",  32'(out_a), 32'h04);
      check_eq("t2_cur",  32'(cur_a), 32'h2);
      step(1'b0, 3'd5, 1'b1, 1'b0, "t2b");
      check_eq("t2_err_pulse", 32'(err_a), 32'h0);

      // HOLD=1 vs HOLD=0.
      do_reset();
      step(1'b1, 3'd0, 1'b1, 1'b0, "t3a");
      check_eq("t3_b_first", 32'(out_b), 32'h01);
      step(1'b1, 3'd3, 1'b1, 1'b0, "t3b");
      check_eq("t3_b_second", 32'(out_b), 32'h08);
      check_eq("t3_a_second", 32'(out_a), 32'h09);

`ifdef DEMUX_SCAN_EN
      // Scan with DWELL=4 (A) and DWELL=1 (B), sel invalid throughout.
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 3'd7, 1'b1, 1'b1, "t4");
         check_eq("t4_cur_a", 32'(cur_a), 32'((k / 4) % 5));
         check_eq("t4_cur_b", 32'(cur_b), 32'(k % 5));
         check_eq("t4_err_a", 32'(err_a), 32'h0);
      end
      check_eq("t4_out_all", 32'(out_a), 32'h1f);

      // Reach ptr=3 on A, then reset between edges.
      for (int k = 0; k < 12; k++) step(1'b0, 3'd0, 1'b0, 1'b1, "t5pre");
      check_eq("t5_cur_pre", 32'(cur_a), 32'h3);
      reset_n = 1'b0;
      #2;
      model_reset();
      check_eq("t5_out_async", 32'(out_a), 32'h0);
      check_eq("t5_cur_async", 32'(cur_a), 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(1'b1, 3'd4, 1'b1, 1'b1, "t5post");
      check_eq("t5_restart_out", 32'(out_a), 32'h01);
      check_eq("t5_restart_cur", 32'(cur_a), 32'h0);
      // Leaving scan applies manual rules on the same edge.
      step(1'b1, 3'd4, 1'b1, 1'b0, "t5exit");
      check_eq("t5_exit_cur", 32'(cur_a), 32'h4);
`else
      // scan is ignored without the macro.
      do_reset();
      step(1'b1, 3'd1, 1'b1, 1'b1, "t6a");
      check_eq("t6_out", 32'(out_a), 32'h02);
      check_eq("t6_cur", 32'(cur_a), 32'h1);
      step(1'b0, 3'd0, 1'b0, 1'b1, "t6b");
      check_eq("t6_cur_hold", 32'(cur_a), 32'h1);
`endif

      // Randomized traffic with occasional scan toggling.
      do_reset();
      begin
         bit sc;
         sc = 1'b0;
         for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) sc = ~sc;
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), sc, "rnd");
            check_eq("rnd_excl_a", 32'((strobe_a != 0) && err_a), 32'h0);
            check_eq("rnd_excl_b", 32'((strobe_b != 0) && err_b), 32'h0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
